nco_sweep_ctrl: RTL and testbench

//  Upstream frequency-plan controller for the NCO: drives its phase-increment input (phi_inc_i).

---
 rtl/nco_sweep_ctrl_pkg.sv | 14 +
 rtl/nco_sweep_ctrl_step.sv | 37 +++
 rtl/nco_sweep_ctrl.sv | 163 ++++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_sweep_ctrl_pkg.sv
// Shared definitions for the NCO sweep controller: sweep modes and FSM states.
package nco_sweep_ctrl_pkg;

    // Sweep modes; code 3 behaves as single-shot.
    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_SAW    = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DWELL = 1'b1
    } state_e;

endpackage

// File: rtl/nco_sweep_ctrl_step.sv
// Combinational next phase increment with clamp at the leg target.
// Ports:
//   cur_i      current increment
//   target_i   endpoint of the current leg
//   step_i     step magnitude (0 jumps straight to target)
//   dir_i      1 = descending leg
//   nxt_c_o    next increment, never past target_i
//   at_end_c_o cur_i already equals target_i
module nco_sweep_ctrl_step #(
    parameter int unsigned APR = 32
) (
    input  logic [APR-1:0] cur_i,
    input  logic [APR-1:0] target_i,
    input  logic [APR-1:0] step_i,
    input  logic           dir_i,
    output logic [APR-1:0] nxt_c_o,
    output logic           at_end_c_o
);

    logic [APR:0]   sum_c;
    logic [APR-1:0] gap_c;

    // Up leg sums one bit wider so a large step can never wrap past target.
    always_comb begin
        sum_c      = {1'b0, cur_i} + {1'b0, step_i};
        gap_c      = cur_i - target_i;
        at_end_c_o = (cur_i == target_i);
        if (step_i == '0) begin
            nxt_c_o = target_i;
        end else if (!dir_i) begin
            nxt_c_o = (sum_c > {1'b0, target_i}) ? target_i : sum_c[APR-1:0];
        end else begin
            nxt_c_o = (gap_c < step_i) ? target_i : (cur_i - step_i);
        end
    end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Stepped linear chirp generator feeding the NCO phase increment.
// Ports:
//   clk, reset_n      NCO clock, async active-low reset
//   en_i              sample tick (NCO clken)
//   start, abort      one-cycle control pulses (abort has priority)
//   mode              0 single, 1 sawtooth, 2 triangle, 3 single
//   f_start, f_stop   sweep endpoints; f_step step magnitude
//   dwell             en_i ticks per step (0 treated as 1)
//   phi_inc_o         registered increment to the NCO
//   busy, done, dir_o sweep active, single-sweep completion pulse, descending
module nco_sweep_ctrl
    import nco_sweep_ctrl_pkg::*;
#(
    parameter int unsigned APR = 32,
    parameter int unsigned DWW = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           en_i,
    input  logic           start,
    input  logic           abort,
    input  logic [1:0]     mode,
    input  logic [APR-1:0] f_start,
    input  logic [APR-1:0] f_stop,
    input  logic [APR-1:0] f_step,
    input  logic [DWW-1:0] dwell,
    output logic [APR-1:0] phi_inc_o,
    output logic           busy,
    output logic           done,
    output logic           dir_o
);

    state_e         state_q, state_d;
    logic [1:0]     mode_q, mode_d;
    logic [APR-1:0] fstart_q, fstart_d;
    logic [APR-1:0] fstop_q, fstop_d;
    logic [APR-1:0] fstep_q, fstep_d;
    logic [DWW-1:0] dwell_q, dwell_d;
    logic [DWW-1:0] cnt_q, cnt_d;
    logic [APR-1:0] phi_q, phi_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           dir_q, dir_d;
    logic           leg_q, leg_d;     // 0 = forward leg toward f_stop

    logic [APR-1:0] target_c;
    logic [APR-1:0] nxt_c;
    logic           at_end_c;
    logic [DWW-1:0] dwell_eff_c;

    assign target_c    = leg_q ? fstart_q : fstop_q;
    assign dwell_eff_c = (dwell == '0) ? DWW'(1) : dwell;

    nco_sweep_ctrl_step #(.APR(APR)) u_step (
        .cur_i      (phi_q),
        .target_i   (target_c),
        .step_i     (fstep_q),
        .dir_i      (dir_q),
        .nxt_c_o    (nxt_c),
        .at_end_c_o (at_end_c)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        fstart_d = fstart_q;
        fstop_d  = fstop_q;
        fstep_d  = fstep_q;
        dwell_d  = dwell_q;
        cnt_d    = cnt_q;
        phi_d    = phi_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dir_d    = dir_q;
        leg_d    = leg_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    mode_d   = mode;
                    fstart_d = f_start;
                    fstop_d  = f_stop;
                    fstep_d  = f_step;
                    dwell_d  = dwell_eff_c;
                    cnt_d    = dwell_eff_c;
                    phi_d    = f_start;
                    busy_d   = 1'b1;
                    dir_d    = (f_start > f_stop);
                    leg_d    = 1'b0;
                    state_d  = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (en_i) begin
                    if (cnt_q > DWW'(1)) begin
                        cnt_d = cnt_q - DWW'(1);
                    end else begin
                        // Dwell expired: advance, or act on the endpoint.
                        cnt_d = dwell_q;
                        if (!at_end_c) begin
                            phi_d = nxt_c;
                        end else begin
                            case (mode_q)
                                MODE_SAW: phi_d = fstart_q;
                                MODE_TRI: begin
                                    dir_d = !dir_q;
                                    leg_d = !leg_q;
                                end
                                default: begin
                                    done_d  = 1'b1;
                                    busy_d  = 1'b0;
                                    state_d = ST_IDLE;
                                end
                            endcase
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_SINGLE;
            fstart_q <= '0;
            fstop_q  <= '0;
            fstep_q  <= '0;
            dwell_q  <= DWW'(1);
            cnt_q    <= DWW'(1);
            phi_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dir_q    <= 1'b0;
            leg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            fstart_q <= fstart_d;
            fstop_q  <= fstop_d;
            fstep_q  <= fstep_d;
            dwell_q  <= dwell_d;
            cnt_q    <= cnt_d;
            phi_q    <= phi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dir_q    <= dir_d;
            leg_q    <= leg_d;
        end
    end

    assign phi_inc_o = phi_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dir_o     = dir_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: directed vector table, hand sequences, random run vs model.
module tb_nco_sweep_ctrl;

    logic        clk;
    logic        reset_n;
    logic        en_i;
    logic        start;
    logic        abort;
    logic [1:0]  mode;
    logic [31:0] f_start;
    logic [31:0] f_stop;
    logic [31:0] f_step;
    logic [15:0] dwell;
    logic [31:0] phi_inc_o;
    logic        busy;
    logic        done;
    logic        dir_o;

    int checks;
    int failures;

    nco_sweep_ctrl #(.APR(32), .DWW(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en_i      (en_i),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .f_start   (f_start),
        .f_stop    (f_stop),
        .f_step    (f_step),
        .dwell     (dwell),
        .phi_inc_o (phi_inc_o),
        .busy      (busy),
        .done      (done),
        .dir_o     (dir_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    // Directed vectors: config plus the expected value held in each dwell.
    typedef struct {
        logic [1:0]  mode;
        logic [31:0] fs;
        logic [31:0] fe;
        logic [31:0] st;
        logic [15:0] dw;
        int          per;
        bit          single;
        int          nval;
        logic [31:0] vals [8];
        logic [7:0]  dirs;
    } vec_t;

    vec_t vecs [9];

    task automatic run_vec(input int id, input vec_t v);
        int hold;
        hold    = ((v.dw == 16'd0) ? 1 : int'(v.dw)) * v.per;
        mode    = v.mode;
        f_start = v.fs;
        f_stop  = v.fe;
        f_step  = v.st;
        dwell   = v.dw;
        en_i    = 1'b0;
        start   = 1'b1;
        clk_step();
        start   = 1'b0;
        for (int i = 0; i < v.nval; i++) begin
            for (int k = 0; k < hold; k++) begin
                chk($sformatf("vec%0d phi[%0d.%0d]", id, i, k), 64'(phi_inc_o), 64'(v.vals[i]));
                chk($sformatf("vec%0d dir[%0d.%0d]", id, i, k), 64'(dir_o), 64'(v.dirs[i]));
                chk($sformatf("vec%0d busy[%0d.%0d]", id, i, k), 64'(busy), 64'd1);
                chk($sformatf("vec%0d done[%0d.%0d]", id, i, k), 64'(done), 64'd0);
                en_i = ((k % v.per) == (v.per - 1));
                clk_step();
            end
        end
        en_i = 1'b0;
        if (v.single) begin
            chk($sformatf("vec%0d done_pulse", id), 64'(done), 64'd1);
            chk($sformatf("vec%0d busy_fall", id), 64'(busy), 64'd0);
            chk($sformatf("vec%0d phi_end", id), 64'(phi_inc_o), 64'(v.vals[v.nval-1]));
            clk_step();
            chk($sformatf("vec%0d done_clear", id), 64'(done), 64'd0);
            chk($sformatf("vec%0d phi_hold", id), 64'(phi_inc_o), 64'(v.vals[v.nval-1]));
        end else begin
            chk($sformatf("vec%0d still_busy", id), 64'(busy), 64'd1);
            chk($sformatf("vec%0d no_done", id), 64'(done), 64'd0);
            abort = 1'b1;
            clk_step();
            abort = 1'b0;
            chk($sformatf("vec%0d abort_busy", id), 64'(busy), 64'd0);
            chk($sformatf("vec%0d abort_done", id), 64'(done), 64'd0);
        end
    endtask

    // Reference model: the whole trajectory is precomputed as a list of dwell values.
    logic [31:0] m_phi;
    logic        m_busy;
    logic        m_done;
    logic        m_dir;
    logic [1:0]  m_mode;
    int          m_ticks;
    int          m_d;
    logic [31:0] m_seq [$];
    logic        m_sdir [$];

    task automatic push_leg(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s, input logic d);
        longint unsigned v;
        longint unsigned lb;
        longint unsigned ls;
        v  = 64'(a);
        lb = 64'(b);
        ls = 64'(s);
        m_seq.push_back(a);
        m_sdir.push_back(d);
        while (v != lb) begin
            if (ls == 0)       v = lb;
            else if (lb > v)   v = (lb - v <= ls) ? lb : v + ls;
            else               v = (v - lb <= ls) ? lb : v - ls;
            m_seq.push_back(32'(v));
            m_sdir.push_back(d);
        end
    endtask

    task automatic model_edge();
        int  idx;
        int  len;
        logic d0;
        m_done = 1'b0;
        if (m_busy) begin
            if (abort) begin
                m_busy = 1'b0;
            end else if (en_i) begin
                m_ticks++;
                idx = m_ticks / m_d;
                len = m_seq.size();
                if ((m_mode == 2'd0 || m_mode == 2'd3) && idx >= len) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end else begin
                    m_phi = m_seq[idx % len];
                    m_dir = m_sdir[idx % len];
                end
            end
        end else if (start && !abort) begin
            m_seq.delete();
            m_sdir.delete();
            m_mode  = mode;
            m_d     = (dwell == 16'd0) ? 1 : int'(dwell);
            d0      = (f_start > f_stop);
            push_leg(f_start, f_stop, f_step, d0);
            if (mode == 2'd2) push_leg(f_stop, f_start, f_step, !d0);
            m_ticks = 0;
            m_phi   = f_start;
            m_dir   = d0;
            m_busy  = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] base;
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        en_i     = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        mode     = 2'd0;
        f_start  = 32'd0;
        f_stop   = 32'd0;
        f_step   = 32'd0;
        dwell    = 16'd0;

        vecs[0] = '{mode:2'd0, fs:32'd100, fe:32'd130, st:32'd10, dw:16'd3, per:1, single:1'b1, nval:4,
                    vals:'{32'd100, 32'd110, 32'd120, 32'd130, 32'd0, 32'd0, 32'd0, 32'd0}, dirs:8'b0000_0000};
        vecs[1] = '{mode:2'd0, fs:32'd50, fe:32'd5, st:32'd20, dw:16'd1, per:1, single:1'b1, nval:4,
                    vals:'{32'd50, 32'd30, 32'd10, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0}, dirs:8'b0000_1111};
        vecs[2] = '{mode:2'd2, fs:32'd0, fe:32'd20, st:32'd10, dw:16'd2, per:1, single:1'b0, nval:8,
                    vals:'{32'd0, 32'd10, 32'd20, 32'd20, 32'd10, 32'd0, 32'd0, 32'd10}, dirs:8'b0011_1000};
        vecs[3] = '{mode:2'd1, fs:32'd0, fe:32'd2, st:32'd1, dw:16'd1, per:4, single:1'b0, nval:6,
                    vals:'{32'd0, 32'd1, 32'd2, 32'd0, 32'd1, 32'd2, 32'd0, 32'd0}, dirs:8'b0000_0000};
        vecs[4] = '{mode:2'd0, fs:32'd7, fe:32'd900, st:32'd0, dw:16'd0, per:1, single:1'b1, nval:2,
                    vals:'{32'd7, 32'd900, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, dirs:8'b0000_0000};
        vecs[5] = '{mode:2'd0, fs:32'hFFFF_FFF0, fe:32'hFFFF_FFFF, st:32'h10, dw:16'd1, per:2, single:1'b1, nval:2,
                    vals:'{32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, dirs:8'b0000_0000};
        vecs[6] = '{mode:2'd3, fs:32'd15, fe:32'd0, st:32'h8000_0000, dw:16'd2, per:1, single:1'b1, nval:2,
                    vals:'{32'd15, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, dirs:8'b0000_0011};
        vecs[7] = '{mode:2'd0, fs:32'd42, fe:32'd42, st:32'd5, dw:16'd2, per:1, single:1'b1, nval:1,
                    vals:'{32'd42, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, dirs:8'b0000_0000};
        vecs[8] = '{mode:2'd1, fs:32'hFFFF_FFFD, fe:32'hFFFF_FFFF, st:32'd2, dw:16'd1, per:1, single:1'b0, nval:4,
                    vals:'{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0},
                    dirs:8'b0000_0000};

        // Reset values, before any clock edge.
        #1;
        chk("rst phi", 64'(phi_inc_o), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst dir", 64'(dir_o), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        clk_step();

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Sawtooth 0->100 step 5 dwell 2; start while busy ignored, then abort+start together.
        mode = 2'd1; f_start = 32'd0; f_stop = 32'd100; f_step = 32'd5; dwell = 16'd2;
        start = 1'b1; clk_step(); start = 1'b0;
        en_i = 1'b1;
        clk_step(); clk_step();
        chk("seq_a phi5", 64'(phi_inc_o), 64'd5);
        mode = 2'd0; f_start = 32'd77; f_stop = 32'd77; dwell = 16'd1;
        start = 1'b1; clk_step(); start = 1'b0;
        chk("seq_a busy_start_ignored", 64'(busy), 64'd1);
        chk("seq_a phi_start_ignored", 64'(phi_inc_o), 64'd5);
        clk_step(); clk_step();
        chk("seq_a phi10", 64'(phi_inc_o), 64'd10);
        start = 1'b1; abort = 1'b1; clk_step(); start = 1'b0; abort = 1'b0;
        chk("seq_a abort_busy", 64'(busy), 64'd0);
        chk("seq_a abort_phi", 64'(phi_inc_o), 64'd10);
        chk("seq_a abort_done", 64'(done), 64'd0);
        repeat (4) clk_step();
        chk("seq_a frozen_phi", 64'(phi_inc_o), 64'd10);
        chk("seq_a idle_busy", 64'(busy), 64'd0);
        chk("seq_a idle_done", 64'(done), 64'd0);
        start = 1'b1; clk_step(); start = 1'b0;
        chk("seq_a restart_phi", 64'(phi_inc_o), 64'd77);
        clk_step();
        chk("seq_a restart_done", 64'(done), 64'd1);

        // Async reset mid-dwell with dwell=0, step=0, then restart.
        en_i = 1'b0; mode = 2'd0; f_start = 32'd600; f_stop = 32'd500; f_step = 32'd0; dwell = 16'd0;
        start = 1'b1; clk_step(); start = 1'b0;
        chk("seq_b phi_start", 64'(phi_inc_o), 64'd600);
        chk("seq_b dir_start", 64'(dir_o), 64'd1);
        clk_step();
        #2 reset_n = 1'b0;
        #1;
        chk("seq_b rst_phi", 64'(phi_inc_o), 64'd0);
        chk("seq_b rst_busy", 64'(busy), 64'd0);
        chk("seq_b rst_dir", 64'(dir_o), 64'd0);
        chk("seq_b rst_done", 64'(done), 64'd0);
        #2 reset_n = 1'b1;
        clk_step();
        start = 1'b1; clk_step(); start = 1'b0;
        en_i = 1'b1;
        chk("seq_b re_phi", 64'(phi_inc_o), 64'd600);
        clk_step();
        chk("seq_b jump_phi", 64'(phi_inc_o), 64'd500);
        chk("seq_b jump_busy", 64'(busy), 64'd1);
        clk_step();
        chk("seq_b done", 64'(done), 64'd1);
        chk("seq_b end_phi", 64'(phi_inc_o), 64'd500);
        en_i = 1'b0;

        // Random run against the trajectory model, starting from reset.
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        m_phi = 32'd0; m_busy = 1'b0; m_done = 1'b0; m_dir = 1'b0;
        m_mode = 2'd0; m_ticks = 0; m_d = 1;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            start   = ($urandom_range(0, 15) == 0);
            abort   = ($urandom_range(0, 149) == 0);
            en_i    = ($urandom_range(0, 3) != 0);
            mode    = 2'($urandom_range(0, 3));
            base    = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFC0 : 32'd0;
            f_start = base + 32'($urandom_range(0, 60));
            f_stop  = base + 32'($urandom_range(0, 60));
            case ($urandom_range(0, 7))
                0:       f_step = 32'($urandom);
                1:       f_step = 32'd0;
                default: f_step = 32'($urandom_range(1, 12));
            endcase
            dwell   = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 3));
            @(posedge clk);
            model_edge();
            #1;
            chk($sformatf("rnd%0d phi", c), 64'(phi_inc_o), 64'(m_phi));
            chk($sformatf("rnd%0d busy", c), 64'(busy), 64'(m_busy));
            chk($sformatf("rnd%0d done", c), 64'(done), 64'(m_done));
            chk($sformatf("rnd%0d dir", c), 64'(dir_o), 64'(m_dir));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
